// File: rtl/usb_pkg.sv
// Shared types and defaults for the USB TX line-coding path.
package usb_pkg;

    // Stuffer FSM: PASS forwards source bits, STUFF owns one slot for the inserted 0.
    typedef enum logic {
        PASS  = 1'b0,
        STUFF = 1'b1
    } stuff_state_t;

    // USB full/low-speed stuffing rule: a 0 after six consecutive 1s.
    localparam int unsigned USB_RUN_LEN = 6;

endpackage

// File: rtl/usb_nrzi_enc.sv
// NRZI level encoder: a raw 0 flips the line level, a raw 1 keeps it.
// The level idles at J (1) out of reset and after clr.
module usb_nrzi_enc (
    input  logic clk,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    input  logic raw,
    output logic line
);

    logic level_q;
    logic level_d;

    // Next level: clr returns to J, an emitted raw 0 toggles, everything else holds.
    always_comb begin
        level_d = level_q;
        if (clr) begin
            level_d = 1'b1;
        end else if (en && !raw) begin
            level_d = ~level_q;
        end
    end

    // Level register; idle state is J.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_d;
        end
    end

    assign line = level_q;

endmodule

// File: rtl/usb_stuff_nrzi_tx.sv
// TX line coder: bit stuffing after RUN_LEN consecutive 1s, optional NRZI,
// paced by bit_tick. The source is stalled through in_ready for the stuffed slot.
module usb_stuff_nrzi_tx
    import usb_pkg::*;
#(
    parameter int unsigned RUN_LEN = USB_RUN_LEN,
    parameter bit          NRZI_EN = 1'b1
) (
    input  logic clk,
    input  logic nRST,
    input  logic clr,
    input  logic bit_tick,
    input  logic in_valid,
    input  logic in_bit,
    input  logic in_last,
    input  logic bypass,
    output logic in_ready,
    output logic out_raw,
    output logic out_bit,
    output logic out_valid,
    output logic stuff_inserted
);

    // Wide enough to hold RUN_LEN itself; the count is parked there while in STUFF.
    localparam int unsigned CNT_W = $clog2(RUN_LEN + 1);

    stuff_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_raw_q, out_raw_d;
    logic             out_valid_q, out_valid_d;
    logic             stuff_q, stuff_d;
    logic             accept;
    logic             run_done;

    assign in_ready = (state_q == PASS) && !clr;
    assign accept   = bit_tick && in_valid && in_ready;
    // This counted 1 is the RUN_LEN-th in a row, so the next slot must be a stuffed 0.
    assign run_done = !bypass && in_bit && (cnt_q == CNT_W'(RUN_LEN - 1));

    // Next state and next outputs; pulses default low, raw bit holds between ticks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_raw_d   = out_raw_q;
        out_valid_d = 1'b0;
        stuff_d     = 1'b0;
        if (clr) begin
            // clr wins over both an offered bit and a pending stuff.
            state_d = PASS;
            cnt_d   = '0;
        end else if (bit_tick) begin
            if (state_q == STUFF) begin
                out_raw_d   = 1'b0;
                out_valid_d = 1'b1;
                stuff_d     = 1'b1;
                cnt_d       = '0;
                state_d     = PASS;
            end else if (accept) begin
                out_raw_d   = in_bit;
                out_valid_d = 1'b1;
                if (run_done) begin
                    // Even on a last bit the stuff goes out first; STUFF clears the count.
                    cnt_d   = CNT_W'(RUN_LEN);
                    state_d = STUFF;
                end else if (bypass || !in_bit || in_last) begin
                    // Bypassed bits, zeros and packet ends all break the run.
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= PASS;
            cnt_q       <= '0;
            out_raw_q   <= 1'b0;
            out_valid_q <= 1'b0;
            stuff_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_raw_q   <= out_raw_d;
            out_valid_q <= out_valid_d;
            stuff_q     <= stuff_d;
        end
    end

    assign out_raw        = out_raw_q;
    assign out_valid      = out_valid_q;
    assign stuff_inserted = stuff_q;

    // The encoder sees the same next-state strobe so its level lines up with out_raw.
    generate
        if (NRZI_EN) begin : gen_nrzi
            usb_nrzi_enc u_nrzi (
                .clk  (clk),
                .nRST (nRST),
                .clr  (clr),
                .en   (out_valid_d),
                .raw  (out_raw_d),
                .line (out_bit)
            );
        end else begin : gen_raw
            assign out_bit = out_raw_q;
        end
    endgenerate

endmodule
